// File: rtl/round_robin_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter and its scan logic.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   // Index width for an n-entry requester vector; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/round_robin_lock_arbiter_rr_pick.sv
// Rotating priority encoder: scans req starting just after `last`, wrapping,
// so `last` itself has the lowest priority.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk the scan order backwards so the earliest hit is the final assignment.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last) + k) % N);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/round_robin_lock_arbiter.sv
// N-way round-robin arbiter where a winner keeps the resource while it keeps
// requesting, up to MAX_HOLD consecutive cycles, then rotates to the next requester.
module round_robin_lock_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   parameter int IW       = idx_width(N),
   parameter int HW       = $clog2(MAX_HOLD + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic          busy,
   output logic [IW-1:0] owner_id,
   output logic          timeout,
   output logic          dbg_state
);

   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   // Handshake: req is a level held by each client; grant[i] high in a cycle
   // means client i owns the resource for that whole cycle. Dropping req ends
   // ownership at the next edge; there is no separate acknowledge.

   arb_state_t    state_q;
   logic [N-1:0]  grant_q;
   logic          busy_q;
   logic [IW-1:0] owner_q;
   logic [IW-1:0] last_q;
   logic [HW-1:0] hold_q;
   logic          timeout_q;

   logic          pick_valid;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  grant_d;
   logic          owner_req;
   logic          rearb;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .last  (last_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      grant_d           = '0;
      grant_d[pick_idx] = 1'b1;
   end

   assign owner_req = req[owner_q];
   // A still-requesting owner at its last allowed cycle is forced to rearbitrate.
   assign rearb     = !owner_req || (hold_q == HOLD_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         owner_q   <= '0;
         last_q    <= IW'(N - 1);
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= OWNED;
                  grant_q <= grant_d;
                  busy_q  <= 1'b1;
                  owner_q <= pick_idx;
                  last_q  <= pick_idx;
                  hold_q  <= '0;
               end
            end
            OWNED: begin
               if (rearb) begin
                  timeout_q <= owner_req;
                  if (pick_valid) begin
                     grant_q <= grant_d;
                     busy_q  <= 1'b1;
                     owner_q <= pick_idx;
                     last_q  <= pick_idx;
                     hold_q  <= '0;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                     hold_q  <= '0;
                  end
               end else begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant     = grant_q;
   assign busy      = busy_q;
   assign owner_id  = owner_q;
   assign timeout   = timeout_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// Directed bench for round_robin_lock_arbiter (N=4, MAX_HOLD=4) with an
// ownership-level reference model and literal expectations.
module tb_round_robin_lock_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] grant;
   logic         busy;
   logic [1:0]   owner_id;
   logic         timeout;
   logic         dbg_state;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Model: who owns the resource, for how many cycles so far, and who owned last.
   int m_owner    = -1;
   int m_held     = 0;
   int m_last     = N - 1;
   int m_owner_id = 0;
   bit m_timeout  = 1'b0;
   int m_win;

   logic [3:0] rnd_req;

   always #5 clk = ~clk;

   round_robin_lock_arbiter #(
      .N        (N),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .grant     (grant),
      .busy      (busy),
      .owner_id  (owner_id),
      .timeout   (timeout),
      .dbg_state (dbg_state)
   );

   function automatic int model_pick(input logic [N-1:0] r, input int lst);
      for (int k = 1; k <= N; k++) begin
         if (r[(lst + k) % N]) return (lst + k) % N;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner    = -1;
         m_held     = 0;
         m_last     = N - 1;
         m_owner_id = 0;
         m_timeout  = 1'b0;
      end else begin
         m_timeout = 1'b0;
         m_win     = -1;
         if (m_owner < 0) begin
            m_win = model_pick(req, m_last);
         end else if (!req[m_owner] || m_held == MAX_HOLD) begin
            m_timeout = req[m_owner];
            m_win     = model_pick(req, m_last);
            if (m_win < 0) m_owner = -1;
         end else begin
            m_held++;
         end
         if (m_win >= 0) begin
            m_owner    = m_win;
            m_last     = m_win;
            m_owner_id = m_win;
            m_held     = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_grant",   32'(grant),     (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
         chk("m_busy",    32'(busy),      32'(m_owner >= 0));
         chk("m_owner",   32'(owner_id),  32'(m_owner_id));
         chk("m_timeout", 32'(timeout),   32'(m_timeout));
         chk("m_state",   32'(dbg_state), 32'(m_owner >= 0));
      end
   end

   task automatic step(input logic [N-1:0] v);
      req = v;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [N-1:0] eg, input logic et);
      chk({name, "_grant"},   32'(grant),   32'(eg));
      chk({name, "_busy"},    32'(busy),    32'(eg != '0));
      chk({name, "_timeout"}, 32'(timeout), 32'(et));
   endtask

   initial begin
      cmp_en = 1'b1;
      rst    = 1'b0;
      req    = '0;
      #7;
      lit("rst", 4'b0000, 1'b0);
      chk("rst_owner", 32'(owner_id), 32'd0);
      #5 rst = 1'b1;
      @(posedge clk);
      #1;

      for (int k = 0; k < 5; k++) begin
         step(4'b0000);
         lit("idle", 4'b0000, 1'b0);
      end

      // All four requesting: MAX_HOLD cycles each, in index order.
      for (int k = 0; k < 20; k++) begin
         step(4'b1111);
         lit("rr_all", 4'(1 << ((k / 4) % 4)), (k > 0) && (k % 4 == 0));
      end
      step(4'b0000);
      lit("rr_release", 4'b0000, 1'b0);
      chk("rr_release_owner", 32'(owner_id), 32'd0);

      step(4'b1000);
      lit("own3", 4'b1000, 1'b0);
      step(4'b1000);
      lit("own3_hold", 4'b1000, 1'b0);
      step(4'b0000);
      lit("own3_rel", 4'b0000, 1'b0);
      chk("own3_rel_owner", 32'(owner_id), 32'd3);

      // Pointer at 3 wraps to 0; owner 0 then hands over to 2 with no bubble.
      step(4'b0101);
      lit("hand_a", 4'b0001, 1'b0);
      step(4'b0101);
      lit("hand_b", 4'b0001, 1'b0);
      step(4'b0100);
      lit("hand_c", 4'b0100, 1'b0);
      chk("hand_c_owner", 32'(owner_id), 32'd2);
      step(4'b0000);
      lit("hand_rel", 4'b0000, 1'b0);

      step(4'b0010);
      lit("wrap_a", 4'b0010, 1'b0);
      step(4'b0000);
      lit("wrap_b", 4'b0000, 1'b0);
      step(4'b0011);
      lit("wrap_c", 4'b0001, 1'b0);
      step(4'b0000);
      lit("wrap_rel", 4'b0000, 1'b0);

      // Lone requester is re-granted at the hold limit with a timeout pulse.
      for (int k = 0; k < 10; k++) begin
         step(4'b0100);
         lit("solo", 4'b0100, (k == 4) || (k == 8));
      end

      #2 rst = 1'b0;
      #1;
      lit("async_rst", 4'b0000, 1'b0);
      chk("async_rst_owner", 32'(owner_id), 32'd0);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      step(4'b0011);
      lit("post_rst", 4'b0001, 1'b0);
      step(4'b0000);

      repeat (30) begin
         rnd_req = 4'($urandom_range(0, 15));
         repeat ($urandom_range(1, 6)) step(rnd_req);
      end
      step(4'b0000);
      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
